tap_ctrl: RTL and testbench
===========================

TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for tck/tms/tdi (legal values 2..3).
REQ-002 The module SHALL have these ports:
  iclk          in   1  system clock (the only clock)
  reset         in   1  asynchronous, active-low reset
  tck           in   1  JTAG TCK pin (asynchronous to iclk)
  tms           in   1  JTAG TMS pin
  tdi           in   1  JTAG TDI pin
  tdo           out  1  JTAG TDO pin
  tdo_oe        out  1  TDO output enable
  ir_so         in   1  serial out of the instruction register chain
  dr_so         in   1  serial out of the selected data register
  s_tdi         out  1  synchronized TDI, fed to the IR/DR serial inputs
  shift_ir      out  1  level: IR shift (1) / capture (0) select
  clk_ir        out  1  one-iclk enable pulse: IR cells capture or shift
  update_ir     out  1  one-iclk pulse: IR shadow latch update
  shift_dr      out  1  DR equivalent of shift_ir
  clk_dr        out  1  DR equivalent of clk_ir
  update_dr     out  1  DR equivalent of update_ir
  tlr           out  1  high while in TEST_LOGIC_RESET
  tap_state     out  4  current state encoding (REQ-006)

Function
REQ-003 tck, tms and tdi SHALL each pass through SYNC_STAGES flops; one further flop on synced tck SHALL give tck_rise (0->1) and tck_fall (1->0), each a single-cycle pulse.
REQ-004 tms and tdi SHALL be sampled at tck_rise, so the edge pulse and its data come from the same synchronizer stage.
REQ-005 The FSM SHALL change state only in the iclk cycle where tck_rise=1, following the IEEE 1149.1 16-state graph on the sampled tms.
REQ-006 State encodings:
  TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5
  SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D
REQ-007 shift_ir SHALL be registered and SHALL equal (state==SH_IR); shift_dr SHALL equal (state==SH_DR).
REQ-008 clk_ir SHALL pulse for exactly one iclk cycle in the tck_rise cycle when the pre-transition state is CAP_IR or SH_IR; clk_dr SHALL do the same for CAP_DR/SH_DR.
REQ-009 update_ir SHALL pulse for one iclk cycle at tck_fall while state==UPD_IR; update_dr SHALL do the same for UPD_DR.
REQ-010 s_tdi SHALL hold the tdi value sampled at the last tck_rise.
REQ-011 tdo SHALL be registered at tck_fall: ir_so while state==SH_IR, dr_so while state==SH_DR, otherwise unchanged.
REQ-012 tdo_oe SHALL be set at tck_fall when state is SH_IR or SH_DR, and cleared at tck_fall otherwise.
REQ-013 Five consecutive tck_rise with tms=1 SHALL reach TLR from any state.
REQ-014 tck_rise and tck_fall are mutually exclusive by construction; with tck static, no output SHALL change except as set by reset.
REQ-015 Latency: a tck pin edge SHALL produce its pulse SYNC_STAGES+1 iclk cycles later; iclk SHALL run at least 2*(SYNC_STAGES+2) times faster than tck.
REQ-016 A tck glitch shorter than one iclk period that the synchronizer does not capture SHALL have no effect.

Reset
REQ-017 Reset low SHALL asynchronously set: state=TLR, tlr=1, all synchronizer and edge flops=0, tdo=0, tdo_oe=0, s_tdi=0, and shift/clk/update outputs=0.
REQ-018 Reset asserted mid-shift SHALL abort the shift with no clk_* or update_* pulse; after release the FSM SHALL stay in TLR until tms=0 is sampled.

Structure
REQ-019 Package jtag_pkg SHALL hold the tap_state_t 4-bit enum (REQ-006 values) and the IR width constant shared with the IR block.
REQ-020 One sub-module, jtag_sync, SHALL hold the synchronizer chain and edge detector; the FSM, strobes and TDO logic stay in tap_ctrl.

Verification
REQ-021 Reset then 5 tck with tms=1 -> tap_state=F, tlr=1, no clk_*/update_* pulses.
REQ-022 From TLR, tms 0,1,1,0,0 -> tap_state C,7,4,E,A; exactly one clk_ir pulse, at the CAP_IR->SH_IR edge.
REQ-023 In SH_IR, shift 8 bits of tdi=0xA5 (LSB first) with tms=1 on the last bit, then tms=1,0 -> 9 clk_ir pulses in total (1 capture + 8 shift), one update_ir pulse in UPD_IR, and an attached 8-bit IR holds 0xA5.
REQ-024 DR path: ir/dr_so driven 1,0,1,1 while shifting 4 bits in SH_DR -> tdo shows 1,0,1,1 on successive tck_fall, tdo_oe=1 only during SH_DR.
REQ-025 Enter PAU_DR (tms 0,1,0) then 3 tck with tms=0 -> state stays 3, no clk_dr pulses; tms 1,0 -> return to SH_DR with shifting resumed.
REQ-026 Assert reset in SH_IR after 3 shifted bits -> immediate TLR, outputs per REQ-017, no update_ir pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encodings, IR width and the 1149.1 next-state graph.
package jtag_pkg;

   localparam int unsigned IR_WIDTH = 8;

   typedef enum logic [3:0] {
      StTlr   = 4'hF,
      StRti   = 4'hC,
      StSelDr = 4'h7,
      StCapDr = 4'h6,
      StShDr  = 4'h2,
      StEx1Dr = 4'h1,
      StPauDr = 4'h3,
      StEx2Dr = 4'h0,
      StUpdDr = 4'h5,
      StSelIr = 4'h4,
      StCapIr = 4'hE,
      StShIr  = 4'hA,
      StEx1Ir = 4'h9,
      StPauIr = 4'hB,
      StEx2Ir = 4'h8,
      StUpdIr = 4'hD
   } tap_state_t;

   function automatic tap_state_t tap_next(input tap_state_t cur, input logic tms);
      tap_state_t nxt;
      unique case (cur)
         StTlr:   nxt = tms ? StTlr   : StRti;
         StRti:   nxt = tms ? StSelDr : StRti;
         StSelDr: nxt = tms ? StSelIr : StCapDr;
         StCapDr: nxt = tms ? StEx1Dr : StShDr;
         StShDr:  nxt = tms ? StEx1Dr : StShDr;
         StEx1Dr: nxt = tms ? StUpdDr : StPauDr;
         StPauDr: nxt = tms ? StEx2Dr : StPauDr;
         StEx2Dr: nxt = tms ? StUpdDr : StShDr;
         StUpdDr: nxt = tms ? StSelDr : StRti;
         StSelIr: nxt = tms ? StTlr   : StCapIr;
         StCapIr: nxt = tms ? StEx1Ir : StShIr;
         StShIr:  nxt = tms ? StEx1Ir : StShIr;
         StEx1Ir: nxt = tms ? StUpdIr : StPauIr;
         StPauIr: nxt = tms ? StEx2Ir : StPauIr;
         StEx2Ir: nxt = tms ? StUpdIr : StShIr;
         StUpdIr: nxt = tms ? StSelDr : StRti;
         default: nxt = StTlr;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jtag_sync.sv
// Synchronizes the JTAG pins into iclk and derives single-cycle tck edge pulses.
module jtag_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic iclk,
   input  logic reset,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   output logic tck_rise,
   output logic tck_fall,
   output logic tms_s,
   output logic tdi_s
);

   logic [SYNC_STAGES-1:0] tck_q;
   logic [SYNC_STAGES-1:0] tms_q;
   logic [SYNC_STAGES-1:0] tdi_q;
   logic                   tck_last;

   always_ff @(posedge iclk or negedge reset) begin
      if (!reset) begin
         tck_q    <= '0;
         tms_q    <= '0;
         tdi_q    <= '0;
         tck_last <= 1'b0;
      end else begin
         tck_q    <= {tck_q[SYNC_STAGES-2:0], tck};
         tms_q    <= {tms_q[SYNC_STAGES-2:0], tms};
         tdi_q    <= {tdi_q[SYNC_STAGES-2:0], tdi};
         tck_last <= tck_q[SYNC_STAGES-1];
      end
   end

   // tms/tdi leave the same stage as the tck edge they belong to.
   assign tck_rise = tck_q[SYNC_STAGES-1] & ~tck_last;
   assign tck_fall = ~tck_q[SYNC_STAGES-1] & tck_last;
   assign tms_s    = tms_q[SYNC_STAGES-1];
   assign tdi_s    = tdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller running entirely in the iclk domain; tck is treated as sampled data.
module tap_ctrl
   import jtag_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       iclk,
   input  logic       reset,
   input  logic       tck,
   input  logic       tms,
   input  logic       tdi,
   output logic       tdo,
   output logic       tdo_oe,
   input  logic       ir_so,
   input  logic       dr_so,
   output logic       s_tdi,
   output logic       shift_ir,
   output logic       clk_ir,
   output logic       update_ir,
   output logic       shift_dr,
   output logic       clk_dr,
   output logic       update_dr,
   output logic       tlr,
   output logic [3:0] tap_state
);

   logic       tck_rise;
   logic       tck_fall;
   logic       tms_s;
   logic       tdi_s;
   tap_state_t state;
   tap_state_t nxt;

   jtag_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .iclk     (iclk),
      .reset    (reset),
      .tck      (tck),
      .tms      (tms),
      .tdi      (tdi),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall),
      .tms_s    (tms_s),
      .tdi_s    (tdi_s)
   );

   assign nxt       = tap_next(state, tms_s);
   assign tap_state = state;

   always_ff @(posedge iclk or negedge reset) begin
      if (!reset) begin
         state     <= StTlr;
         tlr       <= 1'b1;
         s_tdi     <= 1'b0;
         shift_ir  <= 1'b0;
         shift_dr  <= 1'b0;
         clk_ir    <= 1'b0;
         clk_dr    <= 1'b0;
         update_ir <= 1'b0;
         update_dr <= 1'b0;
         tdo       <= 1'b0;
         tdo_oe    <= 1'b0;
      end else begin
         clk_ir    <= 1'b0;
         clk_dr    <= 1'b0;
         update_ir <= 1'b0;
         update_dr <= 1'b0;
         // Lags state by one iclk so cells see the pre-transition mode during clk_* pulses.
         shift_ir  <= (state == StShIr);
         shift_dr  <= (state == StShDr);

         if (tck_rise) begin
            state  <= nxt;
            tlr    <= (nxt == StTlr);
            s_tdi  <= tdi_s;
            clk_ir <= (state == StCapIr) || (state == StShIr);
            clk_dr <= (state == StCapDr) || (state == StShDr);
         end

         if (tck_fall) begin
            update_ir <= (state == StUpdIr);
            update_dr <= (state == StUpdDr);
            tdo_oe    <= (state == StShIr) || (state == StShDr);
            if (state == StShIr) begin
               tdo <= ir_so;
            end else if (state == StShDr) begin
               tdo <= dr_so;
            end
         end
      end
   end

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl with a small 8-bit IR model hung on the IR strobes.
module tb_tap_ctrl;
   import jtag_pkg::*;

   logic       iclk = 1'b0;
   logic       reset = 1'b0;
   logic       tck = 1'b0;
   logic       tms = 1'b0;
   logic       tdi = 1'b0;
   logic       dr_so = 1'b0;
   logic       ir_so;
   logic       tdo, tdo_oe, s_tdi;
   logic       shift_ir, clk_ir, update_ir, shift_dr, clk_dr, update_dr, tlr;
   logic [3:0] tap_state;

   logic [IR_WIDTH-1:0] ir_sr;
   logic [IR_WIDTH-1:0] ir_q;

   int checks = 0;
   int errors = 0;
   int n_clk_ir = 0;
   int n_clk_dr = 0;
   int n_upd_ir = 0;
   int n_upd_dr = 0;

   always #5 iclk = ~iclk;

   tap_ctrl #(
      .SYNC_STAGES (2)
   ) dut (
      .iclk      (iclk),
      .reset     (reset),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo),
      .tdo_oe    (tdo_oe),
      .ir_so     (ir_so),
      .dr_so     (dr_so),
      .s_tdi     (s_tdi),
      .shift_ir  (shift_ir),
      .clk_ir    (clk_ir),
      .update_ir (update_ir),
      .shift_dr  (shift_dr),
      .clk_dr    (clk_dr),
      .update_dr (update_dr),
      .tlr       (tlr),
      .tap_state (tap_state)
   );

   // IR cells: capture 0x01, shift LSB-out, shadow on update.
   always @(posedge iclk or negedge reset) begin
      if (!reset) begin
         ir_sr <= '0;
         ir_q  <= '0;
      end else begin
         if (clk_ir) ir_sr <= shift_ir ? {s_tdi, ir_sr[IR_WIDTH-1:1]} : 8'h01;
         if (update_ir) ir_q <= ir_sr;
      end
   end
   assign ir_so = ir_sr[0];

   always @(negedge iclk) begin
      if (clk_ir === 1'b1) n_clk_ir++;
      if (clk_dr === 1'b1) n_clk_dr++;
      if (update_ir === 1'b1) n_upd_ir++;
      if (update_dr === 1'b1) n_upd_dr++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: sim time limit reached, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge iclk);
      #1;
   endtask

   task automatic tck_cycle(input logic m, input logic d);
      tms = m;
      tdi = d;
      wait_clk(4);
      tck = 1'b1;
      wait_clk(8);
      tck = 1'b0;
      wait_clk(4);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      wait_clk(3);
      checks++;
      if (tap_state !== 4'hF || tlr !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: got %h/%b want F/1", tap_state, tlr);
      end
      checks++;
      if ({tdo, tdo_oe, s_tdi, shift_ir, shift_dr, clk_ir, clk_dr, update_ir, update_dr} !== 9'b0)
      begin
         errors++;
         $display("FAIL reset_outputs: got %b want 000000000",
                  {tdo, tdo_oe, s_tdi, shift_ir, shift_dr, clk_ir, clk_dr, update_ir, update_dr});
      end
      reset = 1'b1;
      wait_clk(2);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hF || tlr !== 1'b1) begin
         errors++;
         $display("FAIL tms_ones_tlr: got %h/%b want F/1", tap_state, tlr);
      end
      checks++;
      if (n_clk_ir + n_clk_dr + n_upd_ir + n_upd_dr != 0) begin
         errors++;
         $display("FAIL tlr_no_pulses: got %0d want 0", n_clk_ir + n_clk_dr + n_upd_ir + n_upd_dr);
      end
   endtask

   task automatic test_ir_path();
      logic [4:0]  seq_tms;
      logic [19:0] seq_st;
      seq_tms = 5'b00110;       // applied LSB first: 0,1,1,0,0
      seq_st  = 20'hAE47C;      // expected C,7,4,E,A
      for (int i = 0; i < 5; i++) begin
         tck_cycle(seq_tms[i], 1'b0);
         checks++;
         if (tap_state !== seq_st[i*4 +: 4]) begin
            errors++;
            $display("FAIL ir_path_step%0d: got %h want %h", i, tap_state, seq_st[i*4 +: 4]);
         end
      end
      checks++;
      if (n_clk_ir != 1) begin
         errors++;
         $display("FAIL ir_capture_pulse: got %0d want 1", n_clk_ir);
      end
      checks++;
      if ({tdo, tdo_oe, shift_ir} !== 3'b111) begin
         errors++;
         $display("FAIL ir_shift_entry: got tdo/oe/shift %b want 111", {tdo, tdo_oe, shift_ir});
      end
   endtask

   task automatic test_ir_shift();
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) tck_cycle(i == 7, pat[i]);
      checks++;
      if (tap_state !== 4'h9 || n_clk_ir != 9) begin
         errors++;
         $display("FAIL ir_shift_exit: got %h/%0d want 9/9", tap_state, n_clk_ir);
      end
      tck_cycle(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hD) begin
         errors++;
         $display("FAIL ir_upd_state: got %h want D", tap_state);
      end
      tck_cycle(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'hC || n_upd_ir != 1 || n_clk_ir != 9) begin
         errors++;
         $display("FAIL ir_update: got %h/%0d/%0d want C/1/9", tap_state, n_upd_ir, n_clk_ir);
      end
      checks++;
      if (ir_q !== 8'hA5 || tdo_oe !== 1'b0) begin
         errors++;
         $display("FAIL ir_value: got %h/%b want a5/0", ir_q, tdo_oe);
      end
   endtask

   task automatic test_dr_path();
      logic [3:0] pat;
      pat = 4'b1101;            // dr_so presented LSB first: 1,0,1,1
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'h6 || tdo_oe !== 1'b0) begin
         errors++;
         $display("FAIL dr_capture: got %h/%b want 6/0", tap_state, tdo_oe);
      end
      for (int i = 0; i < 4; i++) begin
         dr_so = pat[i];
         tck_cycle(1'b0, 1'b0);
         checks++;
         if (tap_state !== 4'h2 || tdo !== pat[i] || tdo_oe !== 1'b1) begin
            errors++;
            $display("FAIL dr_tdo_bit%0d: got %h/%b/%b want 2/%b/1", i, tap_state, tdo, tdo_oe,
                     pat[i]);
         end
      end
      dr_so = 1'b0;
      tck_cycle(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'h1 || tdo !== 1'b1 || tdo_oe !== 1'b0 || n_clk_dr != 5) begin
         errors++;
         $display("FAIL dr_exit: got %h/%b/%b/%0d want 1/1/0/5", tap_state, tdo, tdo_oe, n_clk_dr);
      end
   endtask

   task automatic test_pause();
      int base;
      tck_cycle(1'b0, 1'b0);
      base = n_clk_dr;
      for (int i = 0; i < 3; i++) begin
         tck_cycle(1'b0, 1'b0);
         checks++;
         if (tap_state !== 4'h3) begin
            errors++;
            $display("FAIL pause_hold%0d: got %h want 3", i, tap_state);
         end
      end
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'h2 || n_clk_dr != base) begin
         errors++;
         $display("FAIL pause_resume: got %h/%0d want 2/%0d", tap_state, n_clk_dr, base);
      end
      tck_cycle(1'b0, 1'b1);
      checks++;
      if (n_clk_dr != base + 1 || tdo_oe !== 1'b1) begin
         errors++;
         $display("FAIL resume_shift: got %0d/%b want %0d/1", n_clk_dr, tdo_oe, base + 1);
      end
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'hC || n_upd_dr != 1 || n_upd_ir != 1) begin
         errors++;
         $display("FAIL dr_update: got %h/%0d/%0d want C/1/1", tap_state, n_upd_dr, n_upd_ir);
      end
   endtask

   task automatic test_five_ones();
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hF || tlr !== 1'b1) begin
         errors++;
         $display("FAIL five_ones: got %h/%b want F/1", tap_state, tlr);
      end
      tck_cycle(1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      int base;
      base = n_clk_ir + n_clk_dr + n_upd_ir + n_upd_dr;
      @(posedge iclk);
      #1 tck = 1'b1;
      #3 tck = 1'b0;
      wait_clk(8);
      checks++;
      if (tap_state !== 4'hC || n_clk_ir + n_clk_dr + n_upd_ir + n_upd_dr != base) begin
         errors++;
         $display("FAIL glitch: got %h/%0d want C/%0d", tap_state,
                  n_clk_ir + n_clk_dr + n_upd_ir + n_upd_dr, base);
      end
   endtask

   task automatic test_reset_mid_shift();
      int u_ir, c_ir;
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b1, 1'b0);
      tck_cycle(1'b0, 1'b0);
      tck_cycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
      checks++;
      if (tap_state !== 4'hA || tdo_oe !== 1'b1 || s_tdi !== 1'b1) begin
         errors++;
         $display("FAIL pre_abort: got %h/%b/%b want A/1/1", tap_state, tdo_oe, s_tdi);
      end
      u_ir = n_upd_ir;
      c_ir = n_clk_ir;
      @(posedge iclk);
      #4 reset = 1'b0;
      #1;
      checks++;
      if (tap_state !== 4'hF || tlr !== 1'b1 ||
          {tdo, tdo_oe, s_tdi, shift_ir, shift_dr, clk_ir, clk_dr, update_ir, update_dr} !== 9'b0)
      begin
         errors++;
         $display("FAIL abort_outputs: got %h/%b/%b want F/1/000000000", tap_state, tlr,
                  {tdo, tdo_oe, s_tdi, shift_ir, shift_dr, clk_ir, clk_dr, update_ir, update_dr});
      end
      wait_clk(3);
      reset = 1'b1;
      wait_clk(2);
      for (int i = 0; i < 3; i++) tck_cycle(1'b1, 1'b0);
      checks++;
      if (tap_state !== 4'hF || n_upd_ir != u_ir || n_clk_ir != c_ir) begin
         errors++;
         $display("FAIL abort_no_pulse: got %h/%0d/%0d want F/%0d/%0d", tap_state, n_upd_ir,
                  n_clk_ir, u_ir, c_ir);
      end
      tck_cycle(1'b0, 1'b0);
      checks++;
      if (tap_state !== 4'hC || tlr !== 1'b0) begin
         errors++;
         $display("FAIL leave_tlr: got %h/%b want C/0", tap_state, tlr);
      end
   endtask

   initial begin
      test_reset();
      test_ir_path();
      test_ir_shift();
      test_dr_path();
      test_pause();
      test_five_ones();
      test_glitch();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
